// File: rtl/state_word_loader_if.sv
// ---------------------------------------------------------------------------
// state_word_loader_if
//   Handshake bundle between the narrow word source, the word loader and the
//   AES core / trigger comparator that consume the assembled state.
//
//   Signals:
//     in_word   : input data word (source -> loader)
//     in_valid  : in_word is valid (source -> loader)
//     in_ready  : loader can accept a word this cycle (loader -> source)
//     abort     : discard the partially assembled block (source -> loader)
//     state     : assembled block (loader -> sink)
//     out_valid : state holds a complete block (loader -> sink)
//     out_ready : sink consumes state this cycle (sink -> loader)
//
//   Modports:
//     master : the environment driving words in and consuming blocks
//     slave  : the loader itself
// ---------------------------------------------------------------------------
interface state_word_loader_if #(
  parameter int WORD_W  = 32,
  parameter int STATE_W = 4 * WORD_W
);

  logic [WORD_W-1:0]  in_word;
  logic               in_valid;
  logic               in_ready;
  logic               abort;
  logic [STATE_W-1:0] state;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_word, in_valid, abort, out_ready,
    input  in_ready, state, out_valid
  );

  modport slave (
    input  in_word, in_valid, abort, out_ready,
    output in_ready, state, out_valid
  );

endinterface

// File: rtl/state_word_loader.sv
// ---------------------------------------------------------------------------
// state_word_loader
//   Upstream input stage of the AES datapath. Collects four WORD_W-bit words
//   from a narrow valid/ready bus into one STATE_W-bit block. The first word
//   lands in the most significant slice. An assembly register and an output
//   register form a double buffer so the next block can fill while the
//   current one waits for the downstream consumer.
//
//   Ports:
//     clk      : system clock, rising edge
//     rst      : synchronous active-high reset
//     bus      : state_word_loader_if.slave (word input side + block output)
//     blk_cnt  : count of blocks consumed downstream (optional, see below)
//
//   Optional feature:
//     STATE_LOADER_BLKCNT_EN - when defined, adds the 32-bit blk_cnt output,
//     a wrapping counter of out_valid && out_ready handshakes cleared only by
//     rst.
// ---------------------------------------------------------------------------
module state_word_loader #(
  parameter int WORD_W  = 32,
  parameter int STATE_W = 4 * WORD_W
) (
  input  logic                clk,
  input  logic                rst,
  state_word_loader_if.slave  bus
`ifdef STATE_LOADER_BLKCNT_EN
  ,
  output logic [31:0]         blk_cnt
`endif
);

  // FILL: collecting words. PEND: a complete block sits in the assembly
  // register waiting for the output register to be freed.
  typedef enum logic {
    FILL = 1'b0,
    PEND = 1'b1
  } fsm_t;

  fsm_t               fsm, fsm_nxt;
  logic [1:0]         cnt, cnt_nxt;
  logic [STATE_W-1:0] asm_reg, asm_nxt;
  logic [STATE_W-1:0] out_reg, out_nxt;
  logic               out_vld, out_vld_nxt;

  logic               in_rdy;
  logic               accept;
  logic               consume;
  logic               slot_free;
  logic               loaded;
  logic [STATE_W-1:0] shifted;

  // Ready is a function of registered state only; it is held low while
  // reset is asserted so nothing is taken during reset.
  assign in_rdy    = (fsm == FILL) && !rst;
  assign accept    = bus.in_valid && in_rdy;
  assign consume   = out_vld && bus.out_ready;
  assign slot_free = !out_vld || bus.out_ready;

  // Words shift in from the right, so after four shifts the first word sits
  // in the top slice. The same expression forms the completed block when the
  // fourth word goes straight to the output register.
  assign shifted = {asm_reg[STATE_W-WORD_W-1:0], bus.in_word};

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm     <= FILL;
      cnt     <= 2'd0;
      asm_reg <= '0;
      out_reg <= '0;
      out_vld <= 1'b0;
    end else begin
      fsm     <= fsm_nxt;
      cnt     <= cnt_nxt;
      asm_reg <= asm_nxt;
      out_reg <= out_nxt;
      out_vld <= out_vld_nxt;
    end
  end

  // Next-state and datapath update. abort only acts in FILL and beats a
  // coincident word; PEND ignores it so the complete block is never lost.
  always_comb begin
    fsm_nxt     = fsm;
    cnt_nxt     = cnt;
    asm_nxt     = asm_reg;
    out_nxt     = out_reg;
    out_vld_nxt = out_vld;
    loaded      = 1'b0;

    case (fsm)
      FILL: begin
        if (bus.abort) begin
          cnt_nxt = 2'd0;
        end else if (accept) begin
          if (cnt != 2'd3) begin
            asm_nxt = shifted;
            cnt_nxt = cnt + 2'd1;
          end else if (slot_free) begin
            out_nxt = shifted;
            loaded  = 1'b1;
            cnt_nxt = 2'd0;
          end else begin
            asm_nxt = shifted;
            cnt_nxt = 2'd0;
            fsm_nxt = PEND;
          end
        end

        if (loaded) begin
          out_vld_nxt = 1'b1;
        end else if (consume) begin
          out_vld_nxt = 1'b0;
        end
      end

      PEND: begin
        if (consume) begin
          out_nxt     = asm_reg;
          out_vld_nxt = 1'b1;
          cnt_nxt     = 2'd0;
          fsm_nxt     = FILL;
        end
      end

      default: begin
        fsm_nxt = FILL;
      end
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.state     = out_reg;
  assign bus.out_valid = out_vld;

`ifdef STATE_LOADER_BLKCNT_EN
  // Delivered-block counter; wraps naturally at 2^32 and ignores abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt <= 32'd0;
    end else if (consume) begin
      blk_cnt <= blk_cnt + 32'd1;
    end
  end
`endif

endmodule
